// File: rtl/demux14_buf_pkg.sv
// Shared definitions for the 1:4 registered demultiplexer: lane select codes,
// lane count and the per-lane EMPTY/FULL state encoding.
// Optional feature macro: DEMUX_COUNT_EN (per-lane transfer counters).
package demux14_buf_pkg;

  localparam int unsigned NLANES = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  // One-hot lane strobe for a select code
  function automatic logic [NLANES-1:0] sel_decode(input sel_t sel);
    logic [NLANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux14_buf_if.sv
// Handshake bundle for demux14_buf: one input stream, four output lanes.
// master = producer/consumer side (drives in_*, sel, din, out_ready),
// slave  = demultiplexer side.
// Optional feature macro: DEMUX_COUNT_EN adds cnt_a..cnt_d.
interface demux14_buf_if
  import demux14_buf_pkg::*;
#(
  parameter int unsigned DW = 4
`ifdef DEMUX_COUNT_EN
  , parameter int unsigned CNTW = 8
`endif
) ();

  logic              in_valid;
  logic              in_ready;
  sel_t              sel;
  logic [DW-1:0]     din;
  logic [NLANES-1:0] out_valid;
  logic [NLANES-1:0] out_ready;
  logic [DW-1:0]     a;
  logic [DW-1:0]     b;
  logic [DW-1:0]     c;
  logic [DW-1:0]     d;
`ifdef DEMUX_COUNT_EN
  logic [CNTW-1:0]   cnt_a;
  logic [CNTW-1:0]   cnt_b;
  logic [CNTW-1:0]   cnt_c;
  logic [CNTW-1:0]   cnt_d;
`endif

`ifdef DEMUX_COUNT_EN
  modport master (
    output in_valid, sel, din, out_ready,
    input  in_ready, out_valid, a, b, c, d, cnt_a, cnt_b, cnt_c, cnt_d
  );
  modport slave (
    input  in_valid, sel, din, out_ready,
    output in_ready, out_valid, a, b, c, d, cnt_a, cnt_b, cnt_c, cnt_d
  );
`else
  modport master (
    output in_valid, sel, din, out_ready,
    input  in_ready, out_valid, a, b, c, d
  );
  modport slave (
    input  in_valid, sel, din, out_ready,
    output in_ready, out_valid, a, b, c, d
  );
`endif

endinterface

// File: rtl/demux14_buf_lane.sv
// One output lane of the demultiplexer: a single-word EMPTY/FULL buffer with
// valid/ready drain and an optional wrapping transfer counter.
// Optional feature macro: DEMUX_COUNT_EN.
module demux_lane_buf
  import demux14_buf_pkg::*;
#(
  parameter int unsigned DW = 4
`ifdef DEMUX_COUNT_EN
  , parameter int unsigned CNTW = 8
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [DW-1:0]   din,
  input  logic            ready,
  output logic            valid,
  output logic [DW-1:0]   dout
`ifdef DEMUX_COUNT_EN
  , output logic [CNTW-1:0] cnt
`endif
);

  lane_state_e   state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          drain;
`ifdef DEMUX_COUNT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;
`endif

  // State and data registers; buffered word is discarded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LANE_EMPTY;
      data_q  <= '0;
`ifdef DEMUX_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
`ifdef DEMUX_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next state: a load always wins over a drain so same-lane streaming never bubbles
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drain   = (state_q == LANE_FULL) && ready;
    unique case (state_q)
      LANE_EMPTY: if (load) state_d = LANE_FULL;
      LANE_FULL:  if (!load && ready) state_d = LANE_EMPTY;
      default:    state_d = LANE_EMPTY;
    endcase
    if (load) data_d = din;
`ifdef DEMUX_COUNT_EN
    cnt_d = cnt_q;
    if (drain) cnt_d = cnt_q + CNTW'(1);
`endif
  end

  // Outputs decoded straight from registers
  always_comb begin
    valid = (state_q == LANE_FULL);
    dout  = data_q;
`ifdef DEMUX_COUNT_EN
    cnt   = cnt_q;
`endif
  end

endmodule

// File: rtl/demux14_buf.sv
// Registered 1:4 demultiplexer with valid/ready handshake. Routes din to the
// lane chosen by sel; each lane holds its word until the consumer takes it.
// in_ready only looks at the selected lane, so a stalled lane never blocks
// traffic to the others except when it is the current destination.
// Optional feature macro: DEMUX_COUNT_EN (per-lane transfer counters cnt_a..cnt_d).
module demux14_buf
  import demux14_buf_pkg::*;
#(
  parameter int unsigned DW = 4
`ifdef DEMUX_COUNT_EN
  , parameter int unsigned CNTW = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  demux14_buf_if.slave       dmx
);

  logic [NLANES-1:0] load;
  logic [NLANES-1:0] lane_valid;
  logic [DW-1:0]     lane_data [NLANES];
  logic              in_ready_c;
`ifdef DEMUX_COUNT_EN
  logic [CNTW-1:0]   lane_cnt [NLANES];
`endif

  // Accept when the destination lane is empty or draining; decode load strobes
  always_comb begin
    in_ready_c = ~lane_valid[dmx.sel] | dmx.out_ready[dmx.sel];
    load       = sel_decode(dmx.sel) & {NLANES{dmx.in_valid & in_ready_c}};
  end

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    demux_lane_buf #(
      .DW   (DW)
`ifdef DEMUX_COUNT_EN
      , .CNTW (CNTW)
`endif
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (dmx.din),
      .ready (dmx.out_ready[k]),
      .valid (lane_valid[k]),
      .dout  (lane_data[k])
`ifdef DEMUX_COUNT_EN
      , .cnt (lane_cnt[k])
`endif
    );
  end

  assign dmx.in_ready  = in_ready_c;
  assign dmx.out_valid = lane_valid;
  assign dmx.a         = lane_data[SEL_A];
  assign dmx.b         = lane_data[SEL_B];
  assign dmx.c         = lane_data[SEL_C];
  assign dmx.d         = lane_data[SEL_D];
`ifdef DEMUX_COUNT_EN
  assign dmx.cnt_a     = lane_cnt[SEL_A];
  assign dmx.cnt_b     = lane_cnt[SEL_B];
  assign dmx.cnt_c     = lane_cnt[SEL_C];
  assign dmx.cnt_d     = lane_cnt[SEL_D];
`endif

endmodule
